// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer.
// State and trap-kind enums plus exception cause codes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_REDIRECT
  } state_t;

  typedef enum logic {
    KIND_TRAP,
    KIND_MRET
  } kind_t;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

endpackage

// File: rtl/pipeline_control_hazard_unit.sv
// Load-use compare between decode sources and
// the load destination sitting in execute.
module hazard_unit (
  input  logic       decode_valid,
  input  logic [4:0] decode_rs1,
  input  logic [4:0] decode_rs2,
  input  logic       exec_valid,
  input  logic [4:0] exec_rd,
  input  logic       exec_load,
  output logic       load_use
);

  logic rd_live;
  logic rs_hit;

  assign rd_live  = exec_valid & exec_load
                  & (exec_rd != 5'd0);
  assign rs_hit   = (exec_rd == decode_rs1)
                  | (exec_rd == decode_rs2);
  assign load_use = decode_valid & rd_live & rs_hit;

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline:
// hazards, branch redirect and trap/MRET sequencing.
module pipeline_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            decode_valid,
  input  logic [4:0]      decode_rs1,
  input  logic [4:0]      decode_rs2,
  input  logic            exec_valid,
  input  logic [4:0]      exec_rd,
  input  logic            exec_load,
  input  logic            mem_busy,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            irq_pending,
  input  logic [3:0]      irq_cause,
  output logic            fetch_stall,
  output logic            decode_stall,
  output logic            backend_stall,
  output logic            decode_flush,
  output logic            exec_flush,
  output logic            mem_flush,
  output logic            fetch_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_take,
  output logic [4:0]      trap_cause,
  output logic [XLEN-1:0] trap_pc,
  output logic            mret_take
);

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [4:0]      cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load_use;

  hazard_unit u_hazard (
    .decode_valid (decode_valid),
    .decode_rs1   (decode_rs1),
    .decode_rs2   (decode_rs2),
    .exec_valid   (exec_valid),
    .exec_rd      (exec_rd),
    .exec_load    (exec_load),
    .load_use     (load_use)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      kind_q  <= KIND_TRAP;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    fetch_stall    = 1'b0;
    decode_stall   = 1'b0;
    backend_stall  = 1'b0;
    decode_flush   = 1'b0;
    exec_flush     = 1'b0;
    mem_flush      = 1'b0;
    fetch_redirect = 1'b0;
    redirect_pc    = '0;
    trap_take      = 1'b0;
    trap_cause     = '0;
    trap_pc        = '0;
    mret_take      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (exc_valid | mret_valid | irq_pending) begin
          decode_flush = 1'b1;
          exec_flush   = 1'b1;
          mem_flush    = 1'b1;
          state_d      = ST_DRAIN;
          if (exc_valid) begin
            kind_d  = KIND_TRAP;
            cause_d = {1'b0, exc_cause};
            pc_d    = commit_pc;
          end else if (mret_valid) begin
            kind_d  = KIND_MRET;
          end else begin
            kind_d  = KIND_TRAP;
            cause_d = {1'b1, irq_cause};
            pc_d    = commit_pc;
          end
        end else if (mem_busy) begin
          fetch_stall   = 1'b1;
          decode_stall  = 1'b1;
          backend_stall = 1'b1;
        end else if (branch_taken) begin
          fetch_redirect = 1'b1;
          redirect_pc    = branch_target;
          decode_flush   = 1'b1;
          exec_flush     = 1'b1;
        end else if (load_use) begin
          fetch_stall  = 1'b1;
          decode_stall = 1'b1;
          exec_flush   = 1'b1;
        end
      end
      // Outstanding bus access must finish before redirect.
      ST_DRAIN: begin
        fetch_stall  = 1'b1;
        decode_flush = 1'b1;
        exec_flush   = 1'b1;
        mem_flush    = 1'b1;
        if (!mem_busy) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        fetch_redirect = 1'b1;
        decode_flush   = 1'b1;
        state_d        = ST_RUN;
        if (kind_q == KIND_MRET) begin
          redirect_pc = mepc;
          mret_take   = 1'b1;
        end else begin
          redirect_pc = trap_vector;
          trap_take   = 1'b1;
          trap_cause  = cause_q;
          trap_pc     = pc_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Hold every output low while reset is asserted.
    if (!rstn) begin
      fetch_stall    = 1'b0;
      decode_stall   = 1'b0;
      backend_stall  = 1'b0;
      decode_flush   = 1'b0;
      exec_flush     = 1'b0;
      mem_flush      = 1'b0;
      fetch_redirect = 1'b0;
      redirect_pc    = '0;
      trap_take      = 1'b0;
      trap_cause     = '0;
      trap_pc        = '0;
      mret_take      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: vector table, directed
// trap/MRET/reset sequences and random vs. reference model.
module tb_pipeline_control;
  import pipeline_ctrl_pkg::*;

  typedef struct packed {
    logic        dv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ev;
    logic [4:0]  rd;
    logic        ld;
    logic        busy;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic [3:0]  ecause;
    logic [31:0] cpc;
    logic        mret;
    logic [31:0] mepc;
    logic [31:0] tvec;
    logic        irq;
    logic [3:0]  icause;
  } in_t;

  typedef struct packed {
    logic        fs;
    logic        ds;
    logic        bs;
    logic        df;
    logic        ef;
    logic        mf;
    logic        fr;
    logic [31:0] rpc;
    logic        tt;
    logic [4:0]  tc;
    logic [31:0] tpc;
    logic        mt;
  } out_t;

  typedef struct {
    string       name;
    in_t         i;
    logic [6:0]  bits;
    logic [31:0] rpc;
  } vec_t;

  logic        clk, rstn;
  logic        decode_valid, exec_valid, exec_load;
  logic [4:0]  decode_rs1, decode_rs2, exec_rd;
  logic        mem_busy, branch_taken, exc_valid;
  logic        mret_valid, irq_pending;
  logic [31:0] branch_target, commit_pc, mepc, trap_vector;
  logic [3:0]  exc_cause, irq_cause;
  logic        fetch_stall, decode_stall, backend_stall;
  logic        decode_flush, exec_flush, mem_flush;
  logic        fetch_redirect, trap_take, mret_take;
  logic [31:0] redirect_pc, trap_pc;
  logic [4:0]  trap_cause;

  int   tests = 0;
  int   fails = 0;
  out_t last;

  bit         m_active, m_redir, m_mret;
  logic [4:0] m_cause;
  logic [31:0] m_pc;

  pipeline_control #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .decode_valid(decode_valid),
    .decode_rs1(decode_rs1),
    .decode_rs2(decode_rs2),
    .exec_valid(exec_valid),
    .exec_rd(exec_rd),
    .exec_load(exec_load),
    .mem_busy(mem_busy),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .exc_valid(exc_valid),
    .exc_cause(exc_cause),
    .commit_pc(commit_pc),
    .mret_valid(mret_valid),
    .mepc(mepc),
    .trap_vector(trap_vector),
    .irq_pending(irq_pending),
    .irq_cause(irq_cause),
    .fetch_stall(fetch_stall),
    .decode_stall(decode_stall),
    .backend_stall(backend_stall),
    .decode_flush(decode_flush),
    .exec_flush(exec_flush),
    .mem_flush(mem_flush),
    .fetch_redirect(fetch_redirect),
    .redirect_pc(redirect_pc),
    .trap_take(trap_take),
    .trap_cause(trap_cause),
    .trap_pc(trap_pc),
    .mret_take(mret_take)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v = '0;
    v.tvec = 32'h200;
    v.mepc = 32'h44;
    return v;
  endfunction

  task automatic drive(input in_t v);
    decode_valid  = v.dv;
    decode_rs1    = v.rs1;
    decode_rs2    = v.rs2;
    exec_valid    = v.ev;
    exec_rd       = v.rd;
    exec_load     = v.ld;
    mem_busy      = v.busy;
    branch_taken  = v.br;
    branch_target = v.tgt;
    exc_valid     = v.exc;
    exc_cause     = v.ecause;
    commit_pc     = v.cpc;
    mret_valid    = v.mret;
    mepc          = v.mepc;
    trap_vector   = v.tvec;
    irq_pending   = v.irq;
    irq_cause     = v.icause;
  endtask

  function automatic out_t sample();
    out_t o;
    o.fs  = fetch_stall;
    o.ds  = decode_stall;
    o.bs  = backend_stall;
    o.df  = decode_flush;
    o.ef  = exec_flush;
    o.mf  = mem_flush;
    o.fr  = fetch_redirect;
    o.rpc = redirect_pc;
    o.tt  = trap_take;
    o.tc  = trap_cause;
    o.tpc = trap_pc;
    o.mt  = mret_take;
    return o;
  endfunction

  // Expected outputs from the sequencing rules.
  function automatic out_t model_out(input in_t v);
    out_t o = '0;
    if (!m_active) begin
      if (v.exc || v.mret || v.irq) begin
        o.df = 1; o.ef = 1; o.mf = 1;
      end else if (v.busy) begin
        o.fs = 1; o.ds = 1; o.bs = 1;
      end else if (v.br) begin
        o.fr = 1; o.rpc = v.tgt;
        o.df = 1; o.ef = 1;
      end else if (v.dv && v.ev && v.ld && v.rd != 0
                   && (v.rd == v.rs1 || v.rd == v.rs2)) begin
        o.fs = 1; o.ds = 1; o.ef = 1;
      end
    end else if (!m_redir) begin
      o.fs = 1; o.df = 1; o.ef = 1; o.mf = 1;
    end else begin
      o.fr = 1; o.df = 1;
      if (m_mret) begin
        o.rpc = v.mepc; o.mt = 1;
      end else begin
        o.rpc = v.tvec; o.tt = 1;
        o.tc = m_cause; o.tpc = m_pc;
      end
    end
    return o;
  endfunction

  task automatic model_step(input in_t v);
    if (!m_active) begin
      if (v.exc) begin
        m_active = 1; m_redir = 0; m_mret = 0;
        m_cause = {1'b0, v.ecause}; m_pc = v.cpc;
      end else if (v.mret) begin
        m_active = 1; m_redir = 0; m_mret = 1;
      end else if (v.irq) begin
        m_active = 1; m_redir = 0; m_mret = 0;
        m_cause = {1'b1, v.icause}; m_pc = v.cpc;
      end
    end else if (!m_redir) begin
      if (!v.busy) m_redir = 1;
    end else begin
      m_active = 0; m_redir = 0;
    end
  endtask

  task automatic check(input string name,
                       input out_t act, input out_t exp,
                       input bit full);
    out_t a = act;
    out_t e = exp;
    if (!full) begin
      if (!e.fr) begin a.rpc = '0; e.rpc = '0; end
      if (!e.tt) begin
        a.tc = '0; e.tc = '0;
        a.tpc = '0; e.tpc = '0;
      end
    end
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input string name, input in_t v);
    @(negedge clk);
    drive(v);
    #1;
    last = sample();
    check(name, last, model_out(v), 1'b0);
    if (last.tt && last.mt) begin
      fails++;
      $display("FAIL %s trap_take and mret_take both 1", name);
    end
    model_step(v);
  endtask

  vec_t tbl[$];

  task automatic add(input string n, input in_t i,
                     input logic [6:0] b,
                     input logic [31:0] p);
    vec_t t;
    t.name = n; t.i = i; t.bits = b; t.rpc = p;
    tbl.push_back(t);
  endtask

  initial begin
    in_t v;
    m_active = 0; m_redir = 0; m_mret = 0;
    m_cause = '0; m_pc = '0;
    rstn = 1'b0;
    drive(idle());
    #2;
    check("reset_outputs", sample(), '0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // bits order: fs ds bs df ef mf fr
    v = idle();
    v.dv = 1; v.rs1 = 5; v.rs2 = 1;
    v.ev = 1; v.rd = 5; v.ld = 1;
    add("load_use_rs1", v, 7'b1100100, 0);
    v.rd = 0; v.rs1 = 0;
    add("load_use_x0", v, 7'b0000000, 0);
    v = idle();
    v.dv = 1; v.rs1 = 3; v.rs2 = 7;
    v.ev = 1; v.rd = 7; v.ld = 1;
    add("load_use_rs2", v, 7'b1100100, 0);
    v.ld = 0;
    add("no_load", v, 7'b0000000, 0);
    v.ld = 1; v.dv = 0;
    add("decode_invalid", v, 7'b0000000, 0);
    v.dv = 1; v.ev = 0;
    add("exec_invalid", v, 7'b0000000, 0);
    v = idle();
    v.br = 1; v.tgt = 32'h100;
    add("branch", v, 7'b0001101, 32'h100);
    v.dv = 1; v.rs1 = 9; v.ev = 1; v.rd = 9; v.ld = 1;
    add("branch_over_lu", v, 7'b0001101, 32'h100);
    v.busy = 1;
    add("branch_busy", v, 7'b1110000, 0);
    v = idle();
    v.busy = 1;
    add("busy_only", v, 7'b1110000, 0);

    foreach (tbl[k]) begin
      cycle(tbl[k].name, tbl[k].i);
      chk({tbl[k].name, "_bits"},
          {25'd0, last.fs, last.ds, last.bs,
           last.df, last.ef, last.mf, last.fr},
          {25'd0, tbl[k].bits});
      if (tbl[k].bits[0])
        chk({tbl[k].name, "_pc"}, last.rpc, tbl[k].rpc);
    end

    // Exception, no bus wait: REDIRECT two cycles later.
    v = idle();
    v.exc = 1; v.ecause = CAUSE_ILLEGAL;
    v.cpc = 32'h40;
    cycle("exc_n", v);
    chk("exc_n_flush", {last.df, last.ef, last.mf}, 3'b111);
    cycle("exc_n1", idle());
    chk("exc_n1_tt", last.tt, 0);
    cycle("exc_n2", idle());
    chk("exc_n2_tt", last.tt, 1);
    chk("exc_n2_cause", last.tc, 5'h02);
    chk("exc_n2_pc", last.tpc, 32'h40);
    chk("exc_n2_rpc", last.rpc, 32'h200);
    cycle("exc_n3", idle());
    chk("exc_n3_tt", last.tt, 0);

    // Interrupt while the bus is busy for 3 cycles.
    v = idle();
    v.irq = 1; v.icause = CAUSE_ECALL_M;
    v.cpc = 32'h80; v.busy = 1;
    cycle("irq_n", v);
    cycle("irq_n1", v);
    cycle("irq_n2", v);
    v.busy = 0;
    cycle("irq_n3", v);
    chk("irq_n3_drain", {last.fs, last.tt}, 2'b10);
    v.irq = 0;
    cycle("irq_n4", v);
    chk("irq_n4_tt", last.tt, 1);
    chk("irq_n4_cause", last.tc, 5'h1B);
    chk("irq_n4_pc", last.tpc, 32'h80);

    // Exception beats a same-cycle branch.
    v = idle();
    v.exc = 1; v.ecause = CAUSE_BREAKPOINT;
    v.cpc = 32'h60; v.br = 1; v.tgt = 32'h300;
    cycle("exc_br", v);
    chk("exc_br_nofr", last.fr, 0);
    cycle("exc_br1", idle());
    cycle("exc_br2", idle());
    chk("exc_br2_cause", last.tc, 5'h03);

    // MRET.
    v = idle();
    v.mret = 1;
    cycle("mret_n", v);
    cycle("mret_n1", idle());
    cycle("mret_n2", idle());
    chk("mret_n2_mt", {last.mt, last.tt}, 2'b10);
    chk("mret_n2_rpc", last.rpc, 32'h44);

    // Reset in DRAIN aborts the sequence.
    v = idle();
    v.exc = 1; v.ecause = CAUSE_ILLEGAL; v.cpc = 32'h70;
    cycle("rst_evt", v);
    @(negedge clk);
    v = idle();
    v.busy = 1; v.br = 1; v.tgt = 32'h500;
    drive(v);
    #1;
    check("rst_drain_pre", sample(), model_out(v), 1'b0);
    rstn = 1'b0;
    #1;
    check("rst_drain_zero", sample(), '0, 1'b1);
    m_active = 0; m_redir = 0;
    @(negedge clk);
    drive(idle());
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle("rst_after", idle());
      chk("rst_after_nopulse", {last.tt, last.mt}, 2'b00);
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      v = idle();
      v.dv     = 1'($urandom_range(0, 1));
      v.rs1    = 5'($urandom_range(0, 3));
      v.rs2    = 5'($urandom_range(0, 3));
      v.ev     = 1'($urandom_range(0, 1));
      v.rd     = 5'($urandom_range(0, 3));
      v.ld     = 1'($urandom_range(0, 1));
      v.busy   = ($urandom_range(0, 3) == 0);
      v.br     = ($urandom_range(0, 3) == 0);
      v.tgt    = $urandom;
      v.exc    = ($urandom_range(0, 15) == 0);
      v.ecause = 4'($urandom);
      v.cpc    = $urandom;
      v.mret   = ($urandom_range(0, 15) == 0);
      v.mepc   = $urandom;
      v.tvec   = $urandom;
      v.irq    = ($urandom_range(0, 15) == 0);
      v.icause = 4'($urandom);
      cycle("random", v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
